// File: rtl/instru_fetch_mem_pkg.sv
// Shared constants and types for the clocked instruction memory:
// fill word, pipeline-init PC, FSM states and instruction field positions.
package instru_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    localparam logic [31:0] INIT_PC   = 32'hFFFF_FFFC;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Word-aligned byte address whose word index lies inside a 2**aw deep memory.
    function automatic logic addr_in_map(input logic [31:0] addr, input int aw);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/instru_fetch_mem_if.sv
// Load-stream and fetch/response bundle between the IF stage and the
// instruction memory; master is the pipeline side, slave the memory.
interface instru_fetch_mem_if;

    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_last;
    logic        busy;
    logic        req_valid;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] instru;
    logic [5:0]  ctr;
    logic [5:0]  funcode;
    logic        addr_err;

    modport master (
        output load_valid, load_data, load_last, req_valid, pc, stall, flush,
        input  load_ready, busy, rsp_valid, instru, ctr, funcode, addr_err
    );

    modport slave (
        input  load_valid, load_data, load_last, req_valid, pc, stall, flush,
        output load_ready, busy, rsp_valid, instru, ctr, funcode, addr_err
    );

endinterface

// File: rtl/instru_fetch_mem_ram.sv
// Single-port synchronous RAM: one write or one read per enabled cycle,
// read data registered and held while not reading.
module instru_ram #(
    parameter int DEPTH  = 128,
    parameter int WORD_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // Storage array and read register; contents are rebuilt by CLEAR, so no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instru_fetch_mem.sv
// Clocked instruction memory for stage IF: self-clears to HALT words, takes a
// program over the load stream, then serves one-cycle-latency fetches.
module instru_fetch_mem
    import instru_pkg::*;
#(
    parameter int          DEPTH     = 128,
    parameter int          WORD_W    = 32,
    parameter logic [31:0] HALT_WORD = instru_pkg::HALT_WORD
) (
    input logic               clk,
    input logic               rst_n,
    instru_fetch_mem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e            state_r, state_nxt_s;
    logic [AW-1:0]     clr_idx_r, clr_idx_nxt_s;
    logic [AW-1:0]     ld_idx_r, ld_idx_nxt_s;
    logic              busy_r, load_ready_r;
    logic              rsp_valid_r, use_ram_r, addr_err_r;
    logic              ram_en_s, ram_we_s;
    logic [AW-1:0]     ram_addr_s;
    logic [WORD_W-1:0] ram_wdata_s, ram_rdata_s;
    logic              hs_s, init_pc_s, fetch_ok_s, fetch_err_s, fetch_rd_s;
    logic [31:0]       instru_s;

    assign hs_s        = bus.load_valid && load_ready_r;
    assign init_pc_s   = (bus.pc == INIT_PC);
    assign fetch_ok_s  = bus.req_valid && !init_pc_s && addr_in_map(bus.pc, AW);
    assign fetch_err_s = bus.req_valid && !init_pc_s && !addr_in_map(bus.pc, AW);
    // Only an accepted, in-map fetch touches the RAM, so a stall keeps rdata stable.
    assign fetch_rd_s  = (state_r == ST_RUN) && !bus.flush && !bus.stall && fetch_ok_s;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            clr_idx_r    <= {AW{1'b0}};
            ld_idx_r     <= {AW{1'b0}};
            busy_r       <= 1'b1;
            load_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            clr_idx_r    <= clr_idx_nxt_s;
            ld_idx_r     <= ld_idx_nxt_s;
            busy_r       <= (state_nxt_s != ST_RUN);
            load_ready_r <= (state_nxt_s == ST_LOAD);
        end
    end

    // Next-state, counter advance and RAM port selection.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        ld_idx_nxt_s  = ld_idx_r;
        ram_en_s      = 1'b0;
        ram_we_s      = 1'b0;
        ram_addr_s    = bus.pc[AW+1:2];
        ram_wdata_s   = HALT_WORD;
        case (state_r)
            ST_CLEAR: begin
                ram_en_s   = 1'b1;
                ram_we_s   = 1'b1;
                ram_addr_s = clr_idx_r;
                if (clr_idx_r == LAST_IDX) begin
                    state_nxt_s   = ST_LOAD;
                    clr_idx_nxt_s = {AW{1'b0}};
                end else begin
                    clr_idx_nxt_s = clr_idx_r + AW'(1);
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    ram_en_s     = 1'b1;
                    ram_we_s     = 1'b1;
                    ram_addr_s   = ld_idx_r;
                    ram_wdata_s  = bus.load_data;
                    ld_idx_nxt_s = ld_idx_r + AW'(1);
                    if (bus.load_last || (ld_idx_r == LAST_IDX)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (fetch_rd_s) begin
                    ram_en_s = 1'b1;
                end else begin
                    ram_en_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
    end

    // Response registers: flush beats stall, stall beats a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            use_ram_r   <= 1'b0;
            addr_err_r  <= 1'b0;
        end else if (bus.flush) begin
            rsp_valid_r <= 1'b0;
            use_ram_r   <= 1'b0;
            addr_err_r  <= 1'b0;
        end else if (bus.stall) begin
            rsp_valid_r <= rsp_valid_r;
            use_ram_r   <= use_ram_r;
            addr_err_r  <= addr_err_r;
        end else if (state_r == ST_RUN) begin
            rsp_valid_r <= bus.req_valid;
            use_ram_r   <= fetch_ok_s;
            addr_err_r  <= fetch_err_s;
        end else begin
            rsp_valid_r <= 1'b0;
            use_ram_r   <= 1'b0;
            addr_err_r  <= 1'b0;
        end
    end

    instru_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign instru_s       = use_ram_r ? ram_rdata_s : HALT_WORD;
    assign bus.instru     = instru_s;
    assign bus.ctr        = instru_s[OP_MSB:OP_LSB];
    assign bus.funcode    = instru_s[FN_MSB:FN_LSB];
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.addr_err   = addr_err_r;
    assign bus.busy       = busy_r;
    assign bus.load_ready = load_ready_r;

endmodule

// File: tb/tb_instru_fetch_mem.sv
// Directed bench for instru_fetch_mem: clear timing, program load, fetch,
// address errors, stall/flush interplay and reset during load.
module tb_instru_fetch_mem;

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] W0   = 32'h2008_0005;
    localparam logic [31:0] W1   = 32'h0109_5020;
    localparam logic [31:0] W2   = 32'h1000_FFFF;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    instru_fetch_mem_if bus ();

    instru_fetch_mem #(.DEPTH(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"},  {31'd0, bus.rsp_valid},  32'd0);
        chk({tag, "_instru"},     bus.instru,              HALT);
        chk({tag, "_ctr"},        {26'd0, bus.ctr},        32'h3F);
        chk({tag, "_funcode"},    {26'd0, bus.funcode},    32'h00);
        chk({tag, "_addr_err"},   {31'd0, bus.addr_err},   32'd0);
        chk({tag, "_busy"},       {31'd0, bus.busy},       32'd1);
        chk({tag, "_load_ready"}, {31'd0, bus.load_ready}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.pc        = addr;
        step();
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] exp_w, input logic exp_err);
        chk({tag, "_valid"},   {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_instru"},  bus.instru,             exp_w);
        chk({tag, "_ctr"},     {26'd0, bus.ctr},       {26'd0, exp_w[31:26]});
        chk({tag, "_funcode"}, {26'd0, bus.funcode},   {26'd0, exp_w[5:0]});
        chk({tag, "_err"},     {31'd0, bus.addr_err},  {31'd0, exp_err});
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 32'd0;
        bus.load_last  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.pc         = 32'd0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;

        step();
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // CLEAR spans exactly 128 edges
        for (int i = 0; i < 127; i++) step();
        chk("clr127_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("clr127_busy",  {31'd0, bus.busy},       32'd1);
        step();
        chk("clr128_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("clr128_busy",  {31'd0, bus.busy},       32'd1);

        // Program load; a fetch alongside the last word must be ignored
        bus.load_valid = 1'b1;
        bus.load_data  = W0;
        step();
        bus.load_data  = W1;
        step();
        bus.load_data  = W2;
        bus.load_last  = 1'b1;
        bus.req_valid  = 1'b1;
        bus.pc         = 32'h0;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("run_busy",       {31'd0, bus.busy},       32'd0);
        chk("run_ready",      {31'd0, bus.load_ready}, 32'd0);
        chk("edge_fetch_ign", {31'd0, bus.rsp_valid},  32'd0);

        fetch(32'h10); chk_rsp("unwritten", HALT, 1'b0);
        fetch(32'h0);  chk_rsp("w0", W0, 1'b0);
        fetch(32'h4);  chk_rsp("w1", W1, 1'b0);
        fetch(32'h8);  chk_rsp("w2", W2, 1'b0);
        chk("w2_ctr_hand", {26'd0, bus.ctr}, 32'h04);
        chk("w2_fn_hand",  {26'd0, bus.funcode}, 32'h3F);

        fetch(32'hFFFF_FFFC); chk_rsp("init_pc", HALT, 1'b0);
        fetch(32'h6);         chk_rsp("misalign", HALT, 1'b1);
        fetch(32'h200);       chk_rsp("range", HALT, 1'b1);

        // Stall holds the response and drops the presented request
        fetch(32'h0); chk_rsp("pre_stall", W0, 1'b0);
        bus.stall = 1'b1;
        fetch(32'h4); chk_rsp("stall1", W0, 1'b0);
        fetch(32'h4); chk_rsp("stall2", W0, 1'b0);
        bus.stall = 1'b0;
        fetch(32'h4); chk_rsp("unstall", W1, 1'b0);

        // Flush wins over stall
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        fetch(32'h8);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        chk("flush_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("flush_instru", bus.instru,             HALT);
        chk("flush_err",    {31'd0, bus.addr_err},  32'd0);

        fetch(32'h6);
        bus.req_valid = 1'b0;
        step();
        chk("idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("idle_err",   {31'd0, bus.addr_err},  32'd0);

        // Reset in the middle of a program load
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("run_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) step();
        chk("reclr_ready", {31'd0, bus.load_ready}, 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hAAAA_0001;
        step();
        bus.load_data  = 32'hAAAA_0002;
        step();
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("load_rst");
        bus.req_valid = 1'b1;
        bus.pc        = 32'h0;
        step();
        chk("rst_fetch_ign", {31'd0, bus.rsp_valid}, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 127; i++) step();
        chk("clr2_127_ready", {31'd0, bus.load_ready}, 32'd0);
        step();
        chk("clr2_128_ready", {31'd0, bus.load_ready}, 32'd1);
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 32'h3C01_0001;
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        fetch(32'h4); chk_rsp("lost_w1", HALT, 1'b0);
        fetch(32'h0); chk_rsp("new_w0", 32'h3C01_0001, 1'b0);
        fetch(32'h1FC); chk_rsp("last_idx", HALT, 1'b0);
        bus.req_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
